// File: rtl/counter.sv
// Iteration counter for the shift-and-add multiplier control path.
// After a load it counts clock edges up to LAST, then saturates and flags k.
module counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LAST  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic k
);

    // Terminal count at register width; LAST must fit in WIDTH bits
    localparam logic [WIDTH-1:0] LAST_C = WIDTH'(LAST);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] counter_d;

    // Next count: load restarts, otherwise step until the terminal count and hold there
    always_comb begin
        counter_d = counter;
        if (load) begin
            counter_d = '0;
        end else if (counter != LAST_C) begin
            counter_d = counter + WIDTH'(1);
        end
    end

    // Count register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else begin
            counter <= counter_d;
        end
    end

    // Terminal flag decoded straight from the register, so load never reaches k combinationally
    assign k = (counter == LAST_C);

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: a reference model predicts each edge's result
// into a scoreboard queue, which is drained and compared just after the edge.
module tb_counter;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned LAST  = 4;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             k;
    } exp_t;

    logic clk;
    logic reset;
    logic load;
    logic k;

    int   checks;
    int   errors;
    int   m_cnt;
    exp_t sb_q[$];

    counter #(
        .WIDTH(WIDTH),
        .LAST (LAST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .k    (k)
    );

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock period with the given load; model prediction is queued before the edge
    task automatic step(input logic ld, input string tag);
        exp_t e;
        load = ld;
        if (ld) begin
            m_cnt = 0;
        end else if (m_cnt != int'(LAST)) begin
            m_cnt = m_cnt + 1;
        end
        e.cnt = WIDTH'(m_cnt);
        e.k   = (m_cnt == int'(LAST));
        sb_q.push_back(e);
        #5;
        clk = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_cnt"}, 32'(dut.counter), 32'(e.cnt));
            check({tag, "_k"},   32'(k),           32'(e.k));
        end
        #4;
        clk = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        clk    = 1'b0;
        load   = 1'b0;
        reset  = 1'b0;

        // Async reset with the clock idle
        #2;
        reset = 1'b1;
        #2;
        check("rst_cnt", 32'(dut.counter), 32'd0);
        check("rst_k",   32'(k),           32'd0);
        #3;
        reset = 1'b0;
        #3;
        check("rst_hold_cnt", 32'(dut.counter), 32'd0);

        // Free count from zero to the terminal value
        for (int i = 0; i < 4; i++) step(1'b0, "free");

        // Saturation at LAST
        for (int i = 0; i < 4; i++) step(1'b0, "sat");

        // Reload while k is high, then count again
        step(1'b1, "reload");
        for (int i = 0; i < 4; i++) step(1'b0, "recount");

        // Load held high dominates counting
        for (int i = 0; i < 3; i++) step(1'b1, "loadhold");

        // Count to 2, then pulse reset between edges
        step(1'b0, "pre_rst");
        step(1'b0, "pre_rst");
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_cnt", 32'(dut.counter), 32'd0);
        check("mid_rst_k",   32'(k),           32'd0);
        m_cnt = 0;
        #2;
        reset = 1'b0;
        step(1'b0, "post_rst");
        step(1'b0, "post_rst");

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
